// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared types, widths and op decoding for the iterative multiplier
package mul_pkg;

    localparam int W    = 32;
    localparam int XW   = W + 2;
    localparam int ITER = XW / 2;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;
    localparam logic [1:0] OP_MULHU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_e;

    // {x_signed, y_signed}; MUL shares MULH's pair so the two can hit each other's cache entry
    function automatic logic [1:0] op_signs(input logic [1:0] op);
        case (op)
            OP_MULHSU: return 2'b10;
            OP_MULHU:  return 2'b00;
            default:   return 2'b11;
        endcase
    endfunction

endpackage

// File: rtl/mul_iter_ctrl_if.sv
// rtl/mul_iter_ctrl_if.sv - issue/writeback handshake bundle of the multiply unit
interface mul_iter_ctrl_if;
    import mul_pkg::*;

    logic         i_valid;
    logic         o_ready;
    logic [1:0]   i_mul_op;
    logic [W-1:0] i_x;
    logic [W-1:0] i_y;
    logic         i_flush;
    logic         o_valid;
    logic         i_res_ready;
    logic [W-1:0] o_result;
    logic         o_stall;

    modport master (
        output i_valid, i_mul_op, i_x, i_y, i_flush, i_res_ready,
        input  o_ready, o_valid, o_result, o_stall
    );

    modport slave (
        input  i_valid, i_mul_op, i_x, i_y, i_flush, i_res_ready,
        output o_ready, o_valid, o_result, o_stall
    );

endinterface

// File: rtl/booth_digit_pp.sv
// rtl/booth_digit_pp.sv - radix-4 Booth partial product for one 3-bit multiplier digit
module booth_digit_pp
    import mul_pkg::*;
(
    input  logic [XW-1:0] x_i,
    input  logic [2:0]    digit_i,
    output logic [XW:0]   pp_o
);
    logic [XW:0] x1;
    logic [XW:0] x2;

    assign x1 = {x_i[XW-1], x_i};
    assign x2 = {x_i, 1'b0};

    always_comb begin
        pp_o = '0;
        case (digit_i)
            3'b001, 3'b010: pp_o = x1;
            3'b011:         pp_o = x2;
            3'b100:         pp_o = -x2;
            3'b101, 3'b110: pp_o = -x1;
            default:        pp_o = '0;
        endcase
    end

endmodule

// File: rtl/mul_iter_ctrl.sv
// rtl/mul_iter_ctrl.sv - iterative radix-4 Booth RV32M multiplier with a one-entry result cache
module mul_iter_ctrl
    import mul_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    mul_iter_ctrl_if.slave bus
);
    localparam int CW = $clog2(ITER);

    state_e          state_q;
    logic [XW-1:0]   x_q;
    logic [XW+1:0]   acc_q;
    logic [XW:0]     mpl_q;
    logic [CW-1:0]   cnt_q;
    logic            lo_sel_q;
    logic [1:0]      sp_q;
    logic [W-1:0]    key_y_q;
    logic            ready_q;
    logic            valid_q;
    logic            busy_q;
    logic [W-1:0]    result_q;
    logic            cache_vld_q;
    logic [W-1:0]    cache_x_q;
    logic [W-1:0]    cache_y_q;
    logic [1:0]      cache_sp_q;
    logic [2*W-1:0]  cache_prod_q;

    logic [1:0]      req_sp_d;
    logic [XW-1:0]   req_x_d;
    logic [XW-1:0]   req_y_d;
    logic            accept_d;
    logic            hit_d;
    logic [XW:0]     pp_d;
    logic [XW+1:0]   acc_sum_d;
    logic [2*XW+2:0] pair_d;
    logic [2*W-1:0]  prod_d;

    assign req_sp_d = op_signs(bus.i_mul_op);
    assign req_x_d  = req_sp_d[1] ? {{2{bus.i_x[W-1]}}, bus.i_x} : {2'b00, bus.i_x};
    assign req_y_d  = req_sp_d[0] ? {{2{bus.i_y[W-1]}}, bus.i_y} : {2'b00, bus.i_y};
    assign accept_d = (state_q == IDLE) && bus.i_valid && !bus.i_flush;
    assign hit_d    = cache_vld_q && (cache_x_q == bus.i_x) && (cache_y_q == bus.i_y)
                      && (cache_sp_q == req_sp_d);

    booth_digit_pp u_pp (
        .x_i     (x_q),
        .digit_i (mpl_q[2:0]),
        .pp_o    (pp_d)
    );

    // Accumulator sits above the multiplier; product bits fall into the multiplier field as it drains
    assign acc_sum_d = acc_q + {pp_d[XW], pp_d};
    assign pair_d    = $signed({acc_sum_d, mpl_q}) >>> 2;
    assign prod_d    = pair_d[2*W:1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            x_q          <= '0;
            acc_q        <= '0;
            mpl_q        <= '0;
            cnt_q        <= '0;
            lo_sel_q     <= 1'b0;
            sp_q         <= '0;
            key_y_q      <= '0;
            ready_q      <= 1'b1;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
            result_q     <= '0;
            cache_vld_q  <= 1'b0;
            cache_x_q    <= '0;
            cache_y_q    <= '0;
            cache_sp_q   <= '0;
            cache_prod_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_d) begin
                        ready_q <= 1'b0;
                        if (hit_d) begin
                            state_q  <= DONE;
                            valid_q  <= 1'b1;
                            result_q <= (bus.i_mul_op == OP_MUL) ? cache_prod_q[W-1:0]
                                                                 : cache_prod_q[2*W-1:W];
                        end else begin
                            state_q  <= BUSY;
                            busy_q   <= 1'b1;
                            x_q      <= req_x_d;
                            mpl_q    <= {req_y_d, 1'b0};
                            acc_q    <= '0;
                            cnt_q    <= '0;
                            lo_sel_q <= (bus.i_mul_op == OP_MUL);
                            sp_q     <= req_sp_d;
                            key_y_q  <= bus.i_y;
                        end
                    end
                end
                BUSY: begin
                    if (bus.i_flush) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end else begin
                        acc_q <= pair_d[2*XW+2:XW+1];
                        mpl_q <= pair_d[XW:0];
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CW'(ITER - 1)) begin
                            state_q      <= DONE;
                            busy_q       <= 1'b0;
                            valid_q      <= 1'b1;
                            result_q     <= lo_sel_q ? prod_d[W-1:0] : prod_d[2*W-1:W];
                            cache_vld_q  <= 1'b1;
                            cache_x_q    <= x_q[W-1:0];
                            cache_y_q    <= key_y_q;
                            cache_sp_q   <= sp_q;
                            cache_prod_q <= prod_d;
                        end
                    end
                end
                DONE: begin
                    if (bus.i_flush || bus.i_res_ready) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.o_ready  = ready_q;
    assign bus.o_valid  = valid_q;
    assign bus.o_result = result_q;
    assign bus.o_stall  = busy_q | (valid_q & ~bus.i_res_ready);

endmodule

// File: tb/tb_mul_iter_ctrl.sv
// tb/tb_mul_iter_ctrl.sv - self-checking bench for mul_iter_ctrl against an arithmetic reference
module tb_mul_iter_ctrl;
    import mul_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mul_iter_ctrl_if bus ();

    mul_iter_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    bit          mc_valid = 1'b0;
    logic [31:0] mc_x;
    logic [31:0] mc_y;
    logic [1:0]  mc_sp;
    logic [31:0] corners [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] ref_sp(input logic [1:0] op);
        return {op == 2'b00 || op == 2'b01 || op == 2'b10, op == 2'b00 || op == 2'b01};
    endfunction

    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] x,
                                            input logic [31:0] y);
        longint      xs;
        longint      ys;
        logic [63:0] p;
        xs = (op == 2'b01 || op == 2'b10) ? longint'($signed(x)) : longint'(x);
        ys = (op == 2'b01) ? longint'($signed(y)) : longint'(y);
        p  = 64'(xs * ys);
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    function automatic bit model_hit(input logic [1:0] op, input logic [31:0] x,
                                     input logic [31:0] y);
        return mc_valid && mc_x == x && mc_y == y && mc_sp == ref_sp(op);
    endfunction

    task automatic do_op(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] exp_res, input int backp, input int flush_at);
        bit          hit;
        int          exp_lat;
        int          lat;
        logic [31:0] held;
        hit     = model_hit(op, x, y);
        exp_lat = hit ? 1 : 18;
        check_eq("ready_before_issue", 64'(bus.o_ready), 64'd1);
        bus.i_valid  = 1'b1;
        bus.i_mul_op = op;
        bus.i_x      = x;
        bus.i_y      = y;
        step();
        bus.i_valid = 1'b0;
        lat = 1;
        while (lat < 40) begin
            if (lat == flush_at) begin
                bus.i_flush = 1'b1;
                step();
                bus.i_flush = 1'b0;
                check_eq("flush_ready", 64'(bus.o_ready), 64'd1);
                check_eq("flush_valid", 64'(bus.o_valid), 64'd0);
                if (lat >= exp_lat && !hit) begin
                    mc_valid = 1'b1; mc_x = x; mc_y = y; mc_sp = ref_sp(op);
                end
                return;
            end
            if (bus.o_valid) break;
            check_eq("busy_stall_ready", {62'd0, bus.o_stall, bus.o_ready}, 64'b10);
            step();
            lat++;
        end
        check_eq("latency", 64'(lat), 64'(exp_lat));
        if (!bus.o_valid) return;
        if (!hit) begin
            mc_valid = 1'b1; mc_x = x; mc_y = y; mc_sp = ref_sp(op);
        end
        held = bus.o_result;
        repeat (backp) begin
            check_eq("bp_hold", {29'd0, held, 3'b101},
                     {29'd0, bus.o_result, bus.o_stall, bus.o_ready, bus.o_valid});
            step();
        end
        check_eq("result", 64'(bus.o_result), 64'(exp_res));
        bus.i_res_ready = 1'b1;
        #1;
        check_eq("stall_on_take", 64'(bus.o_stall), 64'd0);
        step();
        bus.i_res_ready = 1'b0;
        check_eq("idle_after_take", {62'd0, bus.o_ready, bus.o_valid}, 64'b10);
    endtask

    initial begin
        logic [31:0] px;
        logic [31:0] py;
        bus.i_valid     = 1'b0;
        bus.i_mul_op    = 2'b00;
        bus.i_x         = '0;
        bus.i_y         = '0;
        bus.i_flush     = 1'b0;
        bus.i_res_ready = 1'b0;
        repeat (2) step();
        check_eq("rst_outputs", {29'd0, bus.o_result, bus.o_ready, bus.o_valid, bus.o_stall},
                 64'b100);
        rst_n = 1'b1;
        step();

        do_op(OP_MULH,   32'hFFFF_FFF8, 32'h1, 32'hFFFF_FFFF, 0, 0);
        do_op(OP_MUL,    32'hFFFF_FFF8, 32'h1, 32'hFFFF_FFF8, 0, 0);
        do_op(OP_MULHU,  32'hFFFF_FFF8, 32'h1, 32'h0000_0000, 0, 0);
        do_op(OP_MULHSU, 32'hFFFF_FFF8, 32'h1, 32'hFFFF_FFFF, 0, 0);
        do_op(OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0, 0);
        do_op(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 0);
        do_op(OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 0, 0);

        // flush alongside a request that would hit the cache: must not be accepted
        bus.i_valid  = 1'b1;
        bus.i_flush  = 1'b1;
        bus.i_mul_op = OP_MUL;
        bus.i_x      = 32'hFFFF_FFFF;
        bus.i_y      = 32'hFFFF_FFFF;
        step();
        bus.i_valid = 1'b0;
        bus.i_flush = 1'b0;
        check_eq("flush_req_idle", {61'd0, bus.o_valid, bus.o_ready, bus.o_stall}, 64'b010);
        step();
        check_eq("flush_req_idle2", {61'd0, bus.o_valid, bus.o_ready, bus.o_stall}, 64'b010);

        do_op(OP_MULH, 32'hDEAD_BEEF, 32'h1234_5678,
              ref_mul(OP_MULH, 32'hDEAD_BEEF, 32'h1234_5678), 5, 0);
        do_op(OP_MULHU, 32'h1234_5678, 32'h9ABC_DEF0,
              ref_mul(OP_MULHU, 32'h1234_5678, 32'h9ABC_DEF0), 0, 9);
        do_op(OP_MULHU, 32'h1234_5678, 32'h9ABC_DEF0,
              ref_mul(OP_MULHU, 32'h1234_5678, 32'h9ABC_DEF0), 0, 0);

        do_op(OP_MUL, 32'd7, 32'd6, 32'd42, 0, 0);
        bus.i_valid  = 1'b1;
        bus.i_mul_op = OP_MULHU;
        bus.i_x      = 32'd3;
        bus.i_y      = 32'd5;
        step();
        bus.i_valid = 1'b0;
        repeat (5) step();
        rst_n = 1'b0;
        #2;
        check_eq("midbusy_rst", {29'd0, bus.o_result, bus.o_ready, bus.o_valid, bus.o_stall},
                 64'b100);
        mc_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        do_op(OP_MUL, 32'd7, 32'd6, 32'd42, 0, 0);

        px = 32'd7;
        py = 32'd6;
        for (int n = 0; n < 1000; n++) begin
            logic [1:0]  op;
            logic [31:0] x;
            logic [31:0] y;
            int          el;
            int          bp;
            int          fa;
            op = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) < 3) begin
                x = px;
                y = py;
            end else begin
                x = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
                y = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
            end
            el = model_hit(op, x, y) ? 1 : 18;
            bp = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 4)) : 0;
            fa = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, el)) : 0;
            do_op(op, x, y, ref_mul(op, x, y), bp, fa);
            px = x;
            py = y;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
